// File: rtl/adaptive_hll_bank.sv
// adaptive_hll_bank
//   HyperLogLog sketch of M = 2^P buckets, one node of the adjacency fabric.
//   The bank sleeps until enough distinct neighbours have touched it. It then
//   ingests hashes at one per cycle through a two-stage max-update pipeline,
//   and returns to sleep after IDLE_TIMEOUT cycles without an accepted hash.
//   A clear sequence zeroes the buckets one per cycle. Any bucket can be read
//   at any time, and the bank keeps a running count of buckets equal to zero.
//
// Ports
//   clk                  rising-edge clock
//   reset_n              synchronous active-low reset
//   connection_attempts  per-neighbour touch strobes (IN_DEGREE)
//   hash_input           hash word (HASH_WIDTH)
//   hash_valid           hash word present
//   hash_ready           bank accepts a hash this cycle (state ACTIVE)
//   clear_req            single-cycle clear request
//   clear_busy           clear pending or in progress
//   rd_en, rd_idx        bucket read strobe and index
//   rd_data, rd_valid    registered read result; write-first with respect to
//                        the bucket update made on the same edge
//   active_state         bank is ACTIVE
//   wakeup_count         saturating count of wakeups (8 bits)
//   zero_count           number of buckets currently equal to zero (P+1 bits)
module adaptive_hll_bank #(
    parameter int P                = 8,
    parameter int HASH_WIDTH       = 64,
    parameter int R                = 6,
    parameter int IN_DEGREE        = 256,
    parameter int WAKEUP_THRESHOLD = 3,
    parameter int IDLE_TIMEOUT     = 1024,
    parameter int IDLE_W           = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [IN_DEGREE-1:0]  connection_attempts,
    input  logic [HASH_WIDTH-1:0] hash_input,
    input  logic                  hash_valid,
    output logic                  hash_ready,
    input  logic                  clear_req,
    output logic                  clear_busy,
    input  logic                  rd_en,
    input  logic [P-1:0]          rd_idx,
    output logic [R-1:0]          rd_data,
    output logic                  rd_valid,
    output logic                  active_state,
    output logic [7:0]            wakeup_count,
    output logic [P:0]            zero_count
);

    localparam int              M         = 1 << P;
    localparam int              L         = HASH_WIDTH - P;
    localparam logic [R-1:0]    RHO_MAX   = '1;
    localparam logic [P-1:0]    LAST_IDX  = '1;
    localparam logic [P:0]      ALL_ZERO  = (P+1)'(M);
    localparam logic [IDLE_W-1:0] IDLE_LAST =
        (IDLE_TIMEOUT == 0) ? '0 : IDLE_W'(IDLE_TIMEOUT - 1);

    typedef enum logic [1:0] {
        SLEEP     = 2'd0,
        ACTIVE    = 2'd1,
        CLR_DRAIN = 2'd2,
        CLEAR     = 2'd3
    } state_t;

    // rho = leading zeros of the low field plus one, clamped to the bucket range
    function automatic logic [R-1:0] rho_of(input logic [L-1:0] f);
        int n;
        n = L;
        for (int i = 0; i < L; i++) begin
            if (f[i]) n = L - 1 - i;
        end
        n = n + 1;
        if (n > int'(RHO_MAX)) return RHO_MAX;
        return R'(n);
    endfunction

    function automatic int popcount(input logic [IN_DEGREE-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < IN_DEGREE; i++) begin
            if (v[i]) c++;
        end
        return c;
    endfunction

    state_t                r_state;
    logic                  r_origin_act;
    logic [IN_DEGREE-1:0]  r_mask;
    logic [IDLE_W-1:0]     r_idle;
    logic [7:0]            r_wake_cnt;
    logic                  r_busy;
    logic [P-1:0]          r_clr_idx;
    logic [R-1:0]          r_bank [M];
    logic [P:0]            r_zero_cnt;
    logic                  r_vld_p1;
    logic [P-1:0]          r_idx_p1;
    logic [R-1:0]          r_rho_p1;
    logic [R-1:0]          r_rd_data;
    logic                  r_rd_valid;

    logic                  w_accept;
    logic                  w_wake;
    logic                  w_wr_en;
    logic [P-1:0]          w_wr_idx;
    logic [R-1:0]          w_wr_val;
    logic                  w_wr_was_zero;

    assign hash_ready   = (r_state == ACTIVE);
    assign active_state = (r_state == ACTIVE);
    assign clear_busy   = r_busy;
    assign wakeup_count = r_wake_cnt;
    assign zero_count   = r_zero_cnt;
    assign rd_data      = r_rd_data;
    assign rd_valid     = r_rd_valid;

    assign w_accept = hash_valid && (r_state == ACTIVE);
    assign w_wake   = popcount(r_mask) >= WAKEUP_THRESHOLD;

    // Single bucket write port: the clear sweep or the stage-2 max update.
    // The drain cycle guarantees the two never coincide.
    always_comb begin
        w_wr_en  = 1'b0;
        w_wr_idx = r_idx_p1;
        w_wr_val = '0;
        if (r_state == CLEAR) begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_clr_idx;
            w_wr_val = '0;
        end else if (r_vld_p1) begin
            w_wr_en  = 1'b1;
            w_wr_idx = r_idx_p1;
            w_wr_val = (r_bank[r_idx_p1] > r_rho_p1) ? r_bank[r_idx_p1] : r_rho_p1;
        end
    end

    assign w_wr_was_zero = (r_bank[w_wr_idx] == '0);

    // Control FSM: wake/sleep, idle timeout and the clear sequence
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= SLEEP;
            r_origin_act <= 1'b0;
            r_mask       <= '0;
            r_idle       <= '0;
            r_wake_cnt   <= '0;
            r_busy       <= 1'b0;
            r_clr_idx    <= '0;
        end else begin
            case (r_state)
                SLEEP: begin
                    if (clear_req) begin
                        // Clear beats a simultaneous wakeup; the mask survives
                        // and is re-evaluated once the clear returns here.
                        r_origin_act <= 1'b0;
                        r_busy       <= 1'b1;
                        r_state      <= CLR_DRAIN;
                        r_mask       <= r_mask | connection_attempts;
                    end else if (w_wake) begin
                        r_state <= ACTIVE;
                        r_mask  <= '0;
                        r_idle  <= '0;
                        if (r_wake_cnt != 8'hFF) r_wake_cnt <= r_wake_cnt + 8'd1;
                    end else begin
                        r_mask <= r_mask | connection_attempts;
                    end
                end
                ACTIVE: begin
                    r_mask <= '0;
                    if (clear_req) begin
                        r_origin_act <= 1'b1;
                        r_busy       <= 1'b1;
                        r_state      <= CLR_DRAIN;
                    end else if (w_accept) begin
                        r_idle <= '0;
                    end else if (IDLE_TIMEOUT != 0 && r_idle == IDLE_LAST) begin
                        r_state <= SLEEP;
                    end else begin
                        r_idle <= r_idle + 1'b1;
                    end
                end
                CLR_DRAIN: begin
                    r_state   <= CLEAR;
                    r_clr_idx <= '0;
                    if (!r_origin_act) r_mask <= r_mask | connection_attempts;
                end
                default: begin
                    if (!r_origin_act) r_mask <= r_mask | connection_attempts;
                    r_clr_idx <= r_clr_idx + 1'b1;
                    if (r_clr_idx == LAST_IDX) begin
                        r_busy  <= 1'b0;
                        r_idle  <= '0;
                        r_state <= r_origin_act ? ACTIVE : SLEEP;
                    end
                end
            endcase
        end
    end

    // Stage 1: capture index and rho of an accepted hash
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_vld_p1 <= 1'b0;
        end else begin
            r_vld_p1 <= w_accept;
        end
        if (w_accept) begin
            r_idx_p1 <= hash_input[HASH_WIDTH-1 -: P];
            r_rho_p1 <= rho_of(hash_input[L-1:0]);
        end
    end

    // Stage 2: bucket write and zero-bucket bookkeeping
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < M; i++) r_bank[i] <= '0;
            r_zero_cnt <= ALL_ZERO;
        end else begin
            if (w_wr_en) r_bank[w_wr_idx] <= w_wr_val;
            if (r_state == CLEAR) begin
                if (r_clr_idx == LAST_IDX) r_zero_cnt <= ALL_ZERO;
                else if (!w_wr_was_zero)   r_zero_cnt <= r_zero_cnt + 1'b1;
            end else if (r_vld_p1 && w_wr_was_zero && r_rho_p1 != '0) begin
                r_zero_cnt <= r_zero_cnt - 1'b1;
            end
        end
    end

    // Read port: forwards the value being written on the same edge
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= rd_en;
            if (rd_en) begin
                r_rd_data <= (w_wr_en && w_wr_idx == rd_idx) ? w_wr_val : r_bank[rd_idx];
            end
        end
    end

endmodule
